// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus defines: default bus widths, default memory wait cycles and
// the arbiter FSM state encodings.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W      = 32;
  localparam int BUS_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr_i and
// wraps, so the first requester found at or after the pointer wins.
module rr_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Scan the requesters in rotated order and grant the first one seen.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = PTR_W'((int'(ptr_i) + i) % N);
      if (!found_s && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-master memory bus arbiter: grants one master, runs a fixed-length
// memory access from latched request fields, then pulses that master's ack.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int RR_MODE     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_req_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            mem_ce_o,
  output logic                            mem_we_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]               mem_wdata_o,
  output logic [DATA_W/8-1:0]             mem_sel_o,
  input  logic [DATA_W-1:0]               mem_rdata_i,
  output logic                            busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   mem_ce_q, mem_ce_d;
  logic                   mem_we_q, mem_we_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  logic [IDX_W-1:0]       arb_ptr_s;
  logic [NUM_MASTERS-1:0] gnt_s;

  // Fixed-priority mode is a rotating search pinned to start at master 0.
  assign arb_ptr_s = (RR_MODE != 0) ? rr_ptr_q : '0;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .PTR_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (m_req_i),
    .ptr_i (arb_ptr_s),
    .gnt_o (gnt_s)
  );

  // Next-state and registered-output decode of the IDLE/ACCESS/DONE FSM.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    mem_ce_d  = 1'b0;
    mem_we_d  = 1'b0;
    ack_d     = '0;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|m_req_i) begin
          state_d  = ST_ACCESS;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          mem_ce_d = 1'b1;
          // The grant is one-hot, so at most one slice is selected here.
          for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_idx_d = gnt_s[i] ? IDX_W'(i) : gnt_idx_d;
            rr_ptr_d  = gnt_s[i] ? IDX_W'((i + 1) % NUM_MASTERS) : rr_ptr_d;
            we_d      = gnt_s[i] ? m_we_i[i] : we_d;
            mem_we_d  = gnt_s[i] ? m_we_i[i] : mem_we_d;
            addr_d    = gnt_s[i] ? m_addr_i[i*ADDR_W +: ADDR_W] : addr_d;
            wdata_d   = gnt_s[i] ? m_wdata_i[i*DATA_W +: DATA_W] : wdata_d;
            sel_d     = gnt_s[i] ? m_sel_i[i*SEL_W +: SEL_W] : sel_d;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d           = ST_DONE;
          ack_d[gnt_idx_q]  = 1'b1;
          rdata_d           = we_q ? rdata_q : mem_rdata_i;
        end else begin
          mem_ce_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      mem_ce_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      mem_ce_q  <= mem_ce_d;
      mem_we_q  <= mem_we_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign m_ack_o     = ack_q;
  assign m_rdata_o   = rdata_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sel_o   = sel_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
- REQ-001 The block SHALL have these parameters:
  - NUM_MASTERS, default 2: number of requesting masters (index 0 = instruction fetch, index 1 = data).
  - ADDR_W, default 32: address width.
  - DATA_W, default 32: data width, a multiple of 8.
  - WAIT_CYCLES, default 2: memory access cycles, at least 1.
  - RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
- REQ-002 The block SHALL have these ports:
  - clk  in  1  clock; all state changes on the rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - m_req_i  in  NUM_MASTERS  per-master request, held until acknowledged.
  - m_we_i  in  NUM_MASTERS  per-master write enable.
  - m_addr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master i occupies slice i.
  - m_wdata_i  in  NUM_MASTERS*DATA_W  packed write data.
  - m_sel_i  in  NUM_MASTERS*DATA_W/8  packed byte selects.
  - m_ack_o  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
  - m_rdata_o  out  DATA_W  read data, valid while any m_ack_o bit is high.
  - mem_ce_o  out  1  memory chip enable.
  - mem_we_o  out  1  memory write enable.
  - mem_addr_o  out  ADDR_W  memory address.
  - mem_wdata_o  out  DATA_W  memory write data.
  - mem_sel_o  out  DATA_W/8  memory byte selects.
  - mem_rdata_i  in  DATA_W  memory read data.
  - busy_o  out  1  high whenever the FSM is not in IDLE.

Function
- REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
- REQ-004 In IDLE with at least one m_req_i bit high, the block SHALL pick a winner, register its index, latch its we/addr/wdata/sel into internal registers, load the wait counter with WAIT_CYCLES, and move to ACCESS at the next edge.
- REQ-005 In IDLE with no request, the block SHALL stay in IDLE and drive mem_ce_o=0.
- REQ-006 In ACCESS, mem_ce_o SHALL be 1 and mem_we/addr/wdata/sel SHALL come only from the latched registers; master inputs changing during ACCESS SHALL have no effect.
- REQ-007 The wait counter SHALL decrement once per ACCESS cycle; when it reaches 1, the block SHALL capture mem_rdata_i into m_rdata_o and move to DONE.
- REQ-008 In DONE, m_ack_o SHALL be high for exactly one cycle, on the granted bit only; the next state SHALL be IDLE.
- REQ-009 Latency: a request first sampled in IDLE in cycle 0 SHALL have mem_ce_o high in cycles 1..WAIT_CYCLES and its ack in cycle WAIT_CYCLES+1; throughput is one transaction per WAIT_CYCLES+2 cycles.
- REQ-010 For reads, m_rdata_o SHALL hold the captured value until the next capture; for writes, m_rdata_o SHALL be left unchanged.
- REQ-011 In round-robin mode, the search SHALL start at (last_grant+1) mod NUM_MASTERS; the pointer SHALL update only on grant and SHALL be 0 after reset.
- REQ-012 In fixed-priority mode, the lowest-index requesting master SHALL win; starvation of higher indices is permitted.
- REQ-013 If a granted master drops m_req_i mid-transaction, the transaction SHALL still complete and its ack pulse SHALL still be issued.
- REQ-014 With WAIT_CYCLES=1, ACCESS SHALL last exactly one cycle.

Reset
- REQ-015 While rst=0, asynchronously: state=IDLE, counter=0, RR pointer=0, grant=0, and all outputs (m_ack_o, m_rdata_o, mem_*_o, busy_o) =0.
- REQ-016 A reset during ACCESS or DONE SHALL abort the transaction with no ack; after release, arbitration SHALL restart from IDLE.

Structure
- REQ-017 The state encodings and the default WAIT_CYCLES SHALL live in the shared defines package alongside the existing bus-width macros.
- REQ-018 Arbitration SHALL be a sub-module, rr_arbiter (request vector plus pointer in, one-hot grant out, combinational).

Verification (NUM_MASTERS=2, WAIT_CYCLES=2, RR_MODE=1 unless stated)
- REQ-019 Master 0 reads address 0x100 with mem_rdata_i=0xDEADBEEF -> mem_ce_o high in cycles 1-2, mem_addr_o=0x100, m_ack_o=01 in cycle 3, m_rdata_o=0xDEADBEEF.
- REQ-020 Master 1 writes address 0x200, data 0x12345678, sel 0011 -> mem_we_o=1, mem_sel_o=0011, mem_wdata_o=0x12345678 in cycles 1-2; m_ack_o=10 in cycle 3.
- REQ-021 Both masters request continuously -> grants alternate 0,1,0,1; with RR_MODE=0, only master 0 is ever acked.
- REQ-022 rst driven low in cycle 1 of ACCESS -> all outputs are 0 immediately, no ack is ever issued, and after release the pending request is served with the full 4-cycle latency.
- REQ-023 Master 0 drops req in cycle 1 and mem_addr_o is observed -> access completes at the latched address and the ack is issued in cycle 3.
- REQ-024 With WAIT_CYCLES=1, a read -> mem_ce_o high for cycle 1 only and the ack in cycle 2.
